// File: rtl/md_scheduler_if.sv
// EX-stage connection of the multiply/divide unit: operation request,
// forwarded operands, D-stage hazard hint, and HI/LO/busy/stall results.
interface md_scheduler_if;
    logic [3:0]  MDOpE;
    logic        StartE;
    logic [31:0] A;
    logic [31:0] B;
    logic        MDInstD;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        StallReq;

    // Pipeline side: issues operations, reads results
    modport master (
        output MDOpE, StartE, A, B, MDInstD,
        input  Busy, HI, LO, StallReq
    );

    // Unit side: the md_scheduler itself
    modport slave (
        input  MDOpE, StartE, A, B, MDInstD,
        output Busy, HI, LO, StallReq
    );
endinterface

// File: rtl/md_scheduler.sv
// Multi-cycle multiply/divide unit for the 5-stage MIPS pipeline.
// Owns HI/LO. The result is computed when the operation starts, held in
// pending registers, and committed to HI/LO when the busy window closes,
// so HI/LO never show a partially finished value.
module md_scheduler #(
    parameter int MULT_CYCLES = 5,   // 1..15
    parameter int DIV_CYCLES  = 10   // 1..15
) (
    input  logic            clk,
    input  logic            reset,
    md_scheduler_if.slave   md
);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6
    } md_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic        pend_we_q, pend_we_d;

    logic        is_md_op;
    logic        mul_signed;
    logic        div_signed;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] prod;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] divisor;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quo;
    logic [31:0] rem;
    logic        div_by_zero;

    // Arithmetic datapath: product, quotient and remainder from A/B
    always_comb begin
        mul_signed = (md.MDOpE == OP_MULT);
        div_signed = (md.MDOpE == OP_DIV);

        // Low 64 bits of a product of sign/zero-extended operands are the
        // same whether the multiply is treated as signed or unsigned, so one
        // multiplier covers mult and multu.
        a_ext = {{32{mul_signed & md.A[31]}}, md.A};
        b_ext = {{32{mul_signed & md.B[31]}}, md.B};
        prod  = a_ext * b_ext;

        // Signed division on magnitudes; this also yields 0x80000000 / -1 =
        // 0x80000000 with remainder 0 without a special case.
        a_neg       = div_signed & md.A[31];
        b_neg       = div_signed & md.B[31];
        a_mag       = a_neg ? (32'd0 - md.A) : md.A;
        b_mag       = b_neg ? (32'd0 - md.B) : md.B;
        div_by_zero = (md.B == 32'd0);
        divisor     = div_by_zero ? 32'd1 : b_mag;
        q_mag       = a_mag / divisor;
        r_mag       = a_mag % divisor;
        quo         = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem         = a_neg ? (32'd0 - r_mag) : r_mag;
    end

    // Sequencing: start in IDLE, count down in RUN, commit HI/LO on 1 -> 0
    always_comb begin
        // NOTE: every _d starts from its _q so no path leaves a latch behind.
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_we_d = pend_we_q;

        case (state_q)
            IDLE: begin
                if (md.StartE) begin
                    case (md.MDOpE)
                        OP_MULT, OP_MULTU: begin
                            state_d   = RUN;
                            cnt_d     = MULT_N;
                            pend_hi_d = prod[63:32];
                            pend_lo_d = prod[31:0];
                            pend_we_d = 1'b1;
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d   = RUN;
                            cnt_d     = DIV_N;
                            pend_hi_d = rem;
                            pend_lo_d = quo;
                            // Divide by zero still runs the full window but
                            // leaves HI/LO untouched at the end.
                            pend_we_d = ~div_by_zero;
                        end
                        OP_MTHI: hi_d = md.A;
                        OP_MTLO: lo_d = md.A;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                // Requests arriving here are ignored; the hazard unit should
                // never send them.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = IDLE;
                    if (pend_we_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset clears everything including pending results
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_we_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge _d values.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_we_q <= pend_we_d;
        end
    end

    // Outputs and combinational hazard request
    always_comb begin
        is_md_op    = (md.MDOpE == OP_MULT) || (md.MDOpE == OP_MULTU) ||
                      (md.MDOpE == OP_DIV)  || (md.MDOpE == OP_DIVU);
        md.Busy     = (state_q == RUN);
        md.HI       = hi_q;
        md.LO       = lo_q;
        md.StallReq = md.MDInstD & ((state_q == RUN) | (md.StartE & is_md_op));
    end

endmodule
